// File: rtl/fec_pkg.sv
// Shared constants and helpers for the Clause 74 (2112,2080) FEC encoder.
package fec_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned DATA_WORDS  = 65;
    localparam int unsigned BLOCK_WORDS = 66;
    localparam int unsigned PN_LEN      = 58;

    // g(x) = x^32 + x^23 + x^21 + x^11 + x^2 + 1, with the implicit x^32 term dropped
    localparam logic [WORD_W-1:0] GEN_POLY = 32'h00A0_0805;

    // PN-2112 window at block start: bit i holds s(i); s0..s39 = 1, s40..s57 = 0101...
    localparam logic [PN_LEN-1:0] PN_SEED = {18'h2_AAAA, 40'hFF_FFFF_FFFF};

    typedef logic [WORD_W-1:0] word_t;

    // Feed one word (data[0] first) through the x^32-premultiplied division by g(x)
    function automatic word_t parity_step(input word_t rem, input word_t data);
        word_t r;
        logic  fb;
        r = rem;
        for (int unsigned i = 0; i < WORD_W; i++) begin
            fb = data[i] ^ r[WORD_W-1];
            r  = {r[WORD_W-2:0], 1'b0} ^ (fb ? GEN_POLY : '0);
        end
        return r;
    endfunction

    // Remainder bit x^31 leaves first, i.e. lands on bit 0
    function automatic word_t bit_rev(input word_t v);
        word_t r;
        for (int unsigned i = 0; i < WORD_W; i++) begin
            r[i] = v[WORD_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fec_pn2112.sv
// PN-2112 scrambler sequence generator, 32 sequence bits per clock.
module fec_pn2112
    import fec_pkg::*;
(
    input  logic              clk,
    input  logic              arst,
    input  logic              load,
    input  logic              advance,
    output logic [WORD_W-1:0] pn_bits
);

    // state_q[i] holds s(n+i); the low 32 bits are the current word's sequence bits
    logic [PN_LEN-1:0] state_q;
    logic [PN_LEN-1:0] state_d;
    logic [PN_LEN-1:0] step;

    // Slide the 58-bit window by 32: s(n+58+t) = s(n+t) ^ s(n+19+t), all already in the window
    always_comb begin
        step = '0;
        step[PN_LEN-WORD_W-1:0] = state_q[PN_LEN-1:WORD_W];
        for (int unsigned t = 0; t < WORD_W; t++) begin
            step[PN_LEN-WORD_W+t] = state_q[t] ^ state_q[19+t];
        end
        if (load) begin
            state_d = PN_SEED;
        end else if (advance) begin
            state_d = step;
        end else begin
            state_d = state_q;
        end
    end

    // Window register, seeded on reset
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= PN_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign pn_bits = state_q[WORD_W-1:0];

endmodule

// File: rtl/fec_gen.sv
// Clause 74 (2112,2080) FEC encoder: parity generation plus PN-2112 scrambling.
module fec_gen
    import fec_pkg::*;
(
    input  logic              clk,
    input  logic              arst,
    input  logic [WORD_W-1:0] din,
    input  logic              parity_sel,
    output logic [WORD_W-1:0] dout
);

    logic [WORD_W-1:0] rem_q;
    logic [WORD_W-1:0] rem_d;
    logic [WORD_W-1:0] dout_q;
    logic [WORD_W-1:0] dout_d;
    logic [WORD_W-1:0] pn_bits;
    logic [WORD_W-1:0] word;

    // The parity slot reseeds the scrambler so the next cycle is word 0 of a new block
    fec_pn2112 u_pn (
        .clk     (clk),
        .arst    (arst),
        .load    (parity_sel),
        .advance (1'b1),
        .pn_bits (pn_bits)
    );

    // Select data or remainder, scramble, and advance or clear the remainder
    always_comb begin
        word   = parity_sel ? bit_rev(rem_q) : din;
        rem_d  = parity_sel ? '0 : parity_step(rem_q, din);
        dout_d = word ^ pn_bits;
    end

    // Remainder and output registers
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rem_q  <= '0;
            dout_q <= '0;
        end else begin
            rem_q  <= rem_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_fec_gen.sv
// Bench for fec_gen: bit-array reference model (long division + PN recurrence).
module tb_fec_gen;

    logic        clk = 1'b0;
    logic        arst = 1'b0;
    logic [31:0] din = '0;
    logic        parity_sel = 1'b0;
    logic [31:0] dout;

    fec_gen dut (
        .clk        (clk),
        .arst       (arst),
        .din        (din),
        .parity_sel (parity_sel),
        .dout       (dout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Cycle counter used to schedule expectations
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          blk;
        int          wd;
        logic [31:0] val;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] cap [0:7][0:65];
    logic [31:0] data_w [0:64];
    logic [31:0] exp_w  [0:65];
    logic [31:0] par_w;
    bit          pn_s   [0:2111];

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int j = 0; j < 32; j++) r[j] = v[31-j];
        return r;
    endfunction

    // x^n mod g(x), bit d = coefficient of x^d
    function automatic logic [31:0] xpow_mod_g(input int n);
        logic [31:0] v;
        v = 32'h1;
        for (int i = 0; i < n; i++) begin
            if (v[31]) v = {v[30:0], 1'b0} ^ 32'h00A0_0805;
            else       v = {v[30:0], 1'b0};
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %08h, required %08h", name, act, req);
        end
    endtask

    task automatic build_pn();
        for (int i = 0; i < 40; i++) pn_s[i] = 1'b1;
        for (int i = 40; i < 58; i++) pn_s[i] = bit'((i - 40) % 2);
        for (int i = 58; i < 2112; i++) pn_s[i] = pn_s[i-58] ^ pn_s[i-39];
    endtask

    // Expected 66 output words for data_w, by polynomial long division over the whole block
    task automatic model_block();
        bit r [0:2111];
        for (int w = 0; w < 65; w++)
            for (int j = 0; j < 32; j++) r[32*w+j] = data_w[w][j];
        for (int i = 2080; i < 2112; i++) r[i] = 1'b0;
        for (int i = 0; i < 2080; i++) begin
            if (r[i]) begin
                r[i]    ^= 1'b1;
                r[i+9]  ^= 1'b1;
                r[i+11] ^= 1'b1;
                r[i+21] ^= 1'b1;
                r[i+30] ^= 1'b1;
                r[i+32] ^= 1'b1;
            end
        end
        for (int j = 0; j < 32; j++) par_w[j] = r[2080+j];
        for (int w = 0; w < 66; w++)
            for (int j = 0; j < 32; j++)
                exp_w[w][j] = ((w < 65) ? data_w[w][j] : par_w[j]) ^ pn_s[32*w+j];
    endtask

    task automatic load_zero();
        for (int w = 0; w < 65; w++) data_w[w] = '0;
    endtask

    // Sample block: first 64 bits from the Annex 74A sample, remainder a fixed pattern
    task automatic load_sample(input bit flip);
        data_w[0] = rev32(32'hA075_0F3B);
        data_w[1] = rev32(32'hF769_80F6);
        for (int w = 2; w < 65; w++)
            data_w[w] = (32'h9E37_79B9 * w) ^ {w[7:0], 24'h5A_3C0F};
        if (flip) data_w[10][7] = ~data_w[10][7];
    endtask

    task automatic drive(input logic [31:0] d, input logic ps, input int blk, input int wd,
                         input logic [31:0] e);
        exp_t t;
        @(posedge clk);
        #2;
        arst       = 1'b0;
        din        = d;
        parity_sel = ps;
        t.due = cyc + 1;
        t.blk = blk;
        t.wd  = wd;
        t.val = e;
        expq.push_back(t);
    endtask

    task automatic send_block(input int blk, input logic [31:0] park);
        model_block();
        for (int w = 0; w < 65; w++) drive(data_w[w], 1'b0, blk, w, exp_w[w]);
        drive(park, 1'b1, blk, 65, exp_w[65]);
    endtask

    // Compare process: dout is zero in reset, otherwise matches the scheduled expectation
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (arst) begin
                check("reset_dout", dout, 32'h0);
            end else begin
                while (expq.size() > 0 && expq[0].due < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missed_blk%0d_w%0d: got no sample, required %08h",
                             expq[0].blk, expq[0].wd, expq[0].val);
                    void'(expq.pop_front());
                end
                if (expq.size() > 0 && expq[0].due == cyc) begin
                    check($sformatf("blk%0d_w%0d", expq[0].blk, expq[0].wd), dout, expq[0].val);
                    cap[expq[0].blk][expq[0].wd] = dout;
                    void'(expq.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] zero_par_word;
        build_pn();

        // Hand-computed values that pin the model
        load_zero();
        model_block();
        check("model_zero_w0", exp_w[0], rev32(32'hFFFF_FFFF));
        check("model_zero_w1", exp_w[1], rev32(32'hFF55_5540));
        check("model_zero_par", par_w, 32'h0);
        zero_par_word = exp_w[65];
        data_w[64] = 32'h8000_0000;
        model_block();
        check("model_m1_par", par_w, rev32(32'h00A0_0805));
        check("model_m1_w65", exp_w[65] ^ zero_par_word, rev32(32'h00A0_0805));
        load_sample(1'b0);
        model_block();
        check("model_sample_w0", exp_w[0], rev32(32'h5F8A_F0C4));
        check("model_sample_w1", exp_w[1], rev32(32'h083C_D5B6));

        // Reset, released in the same slot as word 0 of the first block
        #1 arst = 1'b1;
        repeat (3) @(posedge clk);

        load_zero();
        send_block(0, 32'h0);
        load_sample(1'b0);
        send_block(1, 32'h0);
        send_block(2, 32'hDEAD_BEEF);

        // Partial block, reset pulsed during word 30, then full restart
        model_block();
        for (int w = 0; w < 30; w++) drive(data_w[w], 1'b0, 3, w, exp_w[w]);
        @(posedge clk);
        #2;
        din  = data_w[30];
        arst = 1'b1;
        #1;
        check("reset_immediate", dout, 32'h0);
        repeat (2) @(posedge clk);
        send_block(4, 32'h0);

        load_sample(1'b1);
        send_block(5, 32'h0);

        @(posedge clk);
        #2;
        parity_sel = 1'b0;
        din        = '0;
        repeat (3) @(posedge clk);
        #3;

        if (expq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL pending_expectations: got %0d left, required 0", expq.size());
        end

        check("dut_zero_w0", cap[0][0], rev32(32'hFFFF_FFFF));
        check("dut_zero_w1", cap[0][1], rev32(32'hFF55_5540));
        check("dut_sample_w0", cap[1][0], rev32(32'h5F8A_F0C4));
        check("dut_sample_w1", cap[1][1], rev32(32'h083C_D5B6));
        check("dut_restart_w0", cap[4][0], rev32(32'h5F8A_F0C4));
        for (int w = 0; w < 66; w++) begin
            check($sformatf("b2b_w%0d", w), cap[2][w], cap[1][w]);
            check($sformatf("restart_w%0d", w), cap[4][w], cap[1][w]);
        end
        for (int w = 0; w < 65; w++)
            check($sformatf("flip_diff_w%0d", w), cap[5][w] ^ cap[1][w],
                  (w == 10) ? 32'h0000_0080 : 32'h0);
        // flipped stream bit 327 has degree 2079-327 in m(x); x^32 premultiply gives 2111-327
        check("flip_par_diff", cap[5][65] ^ cap[1][65], rev32(xpow_mod_g(2111 - 327)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
